// File: rtl/cnt_seq_checker.sv
// Consumer-side checker for a free-running counter bus: confirms the bus advances by
// exactly one per qualified sample, locks after a run of good steps, counts errors and wraps.
module cnt_seq_checker #(
    parameter int WIDTH    = 14,
    parameter int LSB_W    = 8,
    parameter int SYNC_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] wrap_count
);

    localparam int HSB_W = WIDTH - LSB_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [3:0]       good_cnt_q, good_cnt_d;
    logic             err_pulse_q, err_pulse_d;
    logic             wrap_pulse_q, wrap_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [ERR_W-1:0] wrap_count_q, wrap_count_d;

    logic [LSB_W-1:0] lo, plo, plo_inc;
    logic [HSB_W-1:0] hi, phi, phi_inc;
    logic             good_step, wrap_step, restart;
    logic             err_inc, wrap_inc;
    logic [3:0]       good_cnt_inc;

    assign lo      = cnt_in[LSB_W-1:0];
    assign hi      = cnt_in[WIDTH-1:LSB_W];
    assign plo     = prev_q[LSB_W-1:0];
    assign phi     = prev_q[WIDTH-1:LSB_W];
    assign plo_inc = plo + LSB_W'(1);
    assign phi_inc = phi + HSB_W'(1);

    // The upper field may hold or advance across a low-field wrap: its carry comes
    // from middle counter bits that are not brought out on the bus.
    assign wrap_step = (plo == '1) && (lo == '0) && ((hi == phi) || (hi == phi_inc));
    assign good_step = ((lo == plo_inc) && (hi == phi)) || wrap_step;
    assign restart   = (cnt_in == '0) && (prev_q != '0) && !good_step;

    assign good_cnt_inc = good_cnt_q + 4'd1;

    function automatic logic [ERR_W-1:0] next_count(input logic [ERR_W-1:0] cur,
                                                    input logic             inc,
                                                    input logic             clr);
        logic [ERR_W-1:0] res;
        res = cur;
        if (clr) begin
            res = inc ? ERR_W'(1) : '0;
        end else if (inc && (cur != '1)) begin
            res = cur + ERR_W'(1);
        end
        return res;
    endfunction

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        good_cnt_d = good_cnt_q;
        err_inc    = 1'b0;
        wrap_inc   = 1'b0;

        if (en) begin
            prev_d = cnt_in;
            case (state_q)
                ST_IDLE: begin
                    good_cnt_d = 4'd0;
                    state_d    = ST_SYNC;
                end
                ST_SYNC: begin
                    if (good_step) begin
                        good_cnt_d = good_cnt_inc;
                        if (good_cnt_inc == 4'(SYNC_CNT)) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        good_cnt_d = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (good_step) begin
                        wrap_inc = wrap_step;
                    end else begin
                        // A jump to zero is the producer restarting, not a fault.
                        err_inc    = !restart;
                        good_cnt_d = 4'd0;
                        state_d    = ST_SYNC;
                    end
                end
                default: begin
                    good_cnt_d = 4'd0;
                    state_d    = ST_IDLE;
                end
            endcase
        end

        err_pulse_d  = err_inc;
        wrap_pulse_d = wrap_inc;
        err_count_d  = next_count(err_count_q, err_inc, clr_err);
        wrap_count_d = next_count(wrap_count_q, wrap_inc, clr_err);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            prev_q       <= '0;
            good_cnt_q   <= 4'd0;
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            good_cnt_q   <= good_cnt_d;
            err_pulse_q  <= err_pulse_d;
            wrap_pulse_q <= wrap_pulse_d;
            err_count_q  <= err_count_d;
            wrap_count_q <= wrap_count_d;
        end
    end

    assign locked     = (state_q == ST_LOCKED);
    assign err_pulse  = err_pulse_q;
    assign wrap_pulse = wrap_pulse_q;
    assign err_count  = err_count_q;
    assign wrap_count = wrap_count_q;

endmodule
